// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a single memory port
// Define ARB_TIMEOUT_EN to abort a stalled BUSY transaction after TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int WIDTH          = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wdata_i,
  output logic                  req0_ready_o,
  output logic [WIDTH-1:0]      req0_rdata_o,
  output logic                  req0_err_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wdata_i,
  output logic                  req1_ready_o,
  output logic [WIDTH-1:0]      req1_rdata_o,
  output logic                  req1_err_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_q, last_d;
  logic   busy, done, abort, finish;
  logic                  g_wr_rd;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [WIDTH-1:0]      g_wdata;

  assign busy    = (state_q == BUSY);
  assign g_wr_rd = grant_q ? req1_wr_rd_i : req0_wr_rd_i;
  assign g_addr  = grant_q ? req1_addr_i  : req0_addr_i;
  assign g_wdata = grant_q ? req1_wdata_i : req0_wdata_i;
  assign done    = busy & mem_ready_i;
  assign finish  = done | abort;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the stalled BUSY cycle that brings the stall count to TIMEOUT_CYCLES.
  assign abort = busy & ~mem_ready_i & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!mem_ready_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign abort          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (req0_valid_i | req1_valid_i) begin
        state_d = BUSY;
        // Contention goes to whoever was not served last.
        grant_d = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
      end
    end else if (finish) begin
      state_d = IDLE;
      last_d  = grant_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign mem_valid_o  = busy;
  assign mem_wr_rd_o  = busy & g_wr_rd;
  assign mem_addr_o   = busy ? g_addr  : '0;
  assign mem_wdata_o  = busy ? g_wdata : '0;

  assign req0_ready_o = finish & ~grant_q;
  assign req1_ready_o = finish &  grant_q;
  assign req0_err_o   = abort  & ~grant_q;
  assign req1_err_o   = abort  &  grant_q;
  assign req0_rdata_o = (done & ~grant_q & ~g_wr_rd) ? mem_rdata_i : '0;
  assign req1_rdata_o = (done &  grant_q & ~g_wr_rd) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (vector table, corner sequences, random vs model)
module tb_mem_arbiter;
  localparam int W  = 8;
  localparam int AW = 4;
  localparam int T  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 0, w0 = 0, v1 = 0, w1 = 0, mr = 0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [W-1:0]  d0 = '0, d1 = '0, mrd = '0;
  logic r0, r1, e0, e1, mv, mw;
  logic [W-1:0]  rd0, rd1, md;
  logic [AW-1:0] ma;
  logic [33:0]   obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .req0_valid_i(v0), .req0_wr_rd_i(w0), .req0_addr_i(a0), .req0_wdata_i(d0),
    .req0_ready_o(r0), .req0_rdata_o(rd0), .req0_err_o(e0),
    .req1_valid_i(v1), .req1_wr_rd_i(w1), .req1_addr_i(a1), .req1_wdata_i(d1),
    .req1_ready_o(r1), .req1_rdata_o(rd1), .req1_err_o(e1),
    .mem_valid_o(mv), .mem_wr_rd_o(mw), .mem_addr_o(ma), .mem_wdata_o(md),
    .mem_ready_i(mr), .mem_rdata_i(mrd)
  );

  assign obs = {mv, mw, ma, md, r0, r1, e0, e1, rd0, rd1};

  typedef struct {
    logic        iv0, iw0;
    logic [3:0]  ia0;
    logic [7:0]  id0;
    logic        iv1, iw1;
    logic [3:0]  ia1;
    logic [7:0]  id1;
    logic        imr;
    logic [7:0]  imrd;
    logic [33:0] want;
  } vec_t;

  function automatic logic [33:0] pk(input logic xmv, input logic xmw, input logic [3:0] xma,
                                     input logic [7:0] xmd, input logic xr0, input logic xr1,
                                     input logic xe0, input logic xe1, input logic [7:0] xrd0,
                                     input logic [7:0] xrd1);
    return {xmv, xmw, xma, xmd, xr0, xr1, xe0, xe1, xrd0, xrd1};
  endfunction

  function automatic vec_t mkv(input logic xv0, input logic xw0, input logic [3:0] xa0,
                               input logic [7:0] xd0, input logic xv1, input logic xw1,
                               input logic [3:0] xa1, input logic [7:0] xd1, input logic xmr,
                               input logic [7:0] xmrd, input logic [33:0] xwant);
    vec_t v;
    v.iv0 = xv0; v.iw0 = xw0; v.ia0 = xa0; v.id0 = xd0;
    v.iv1 = xv1; v.iw1 = xw1; v.ia1 = xa1; v.id1 = xd1;
    v.imr = xmr; v.imrd = xmrd; v.want = xwant;
    return v;
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[16];
  logic [33:0] z;
  int order[$];

  // Random-phase model state
  int owner, last, busy_n;
  logic pv[2], pw[2], strobed[2];
  logic [3:0] pa[2];
  logic [7:0] pd[2];

  initial begin
    z = '0;
    tbl[0]  = mkv(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,8'h00, z);
    tbl[1]  = mkv(1,1,4'd3,8'hA5, 0,0,4'd0,8'h00, 1,8'hEE, z);
    tbl[2]  = mkv(1,1,4'd3,8'hA5, 0,0,4'd0,8'h00, 0,8'h00, pk(1,1,4'd3,8'hA5,0,0,0,0,8'h00,8'h00));
    tbl[3]  = mkv(1,1,4'd3,8'hA5, 0,0,4'd0,8'h00, 1,8'hFF, pk(1,1,4'd3,8'hA5,1,0,0,0,8'h00,8'h00));
    tbl[4]  = mkv(0,0,4'd0,8'h00, 1,0,4'd7,8'h11, 0,8'h00, z);
    tbl[5]  = mkv(0,0,4'd0,8'h00, 1,0,4'd7,8'h11, 1,8'h3C, pk(1,0,4'd7,8'h11,0,1,0,0,8'h00,8'h3C));
    tbl[6]  = mkv(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 1,8'h3C, z);
    tbl[7]  = mkv(1,0,4'd1,8'h10, 1,1,4'd2,8'h22, 0,8'h00, z);
    tbl[8]  = mkv(1,0,4'd1,8'h10, 1,1,4'd2,8'h22, 1,8'h5A, pk(1,0,4'd1,8'h10,1,0,0,0,8'h5A,8'h00));
    tbl[9]  = mkv(1,0,4'd1,8'h10, 1,1,4'd2,8'h22, 0,8'h00, z);
    tbl[10] = mkv(1,0,4'd1,8'h10, 1,1,4'd2,8'h22, 0,8'h00, pk(1,1,4'd2,8'h22,0,0,0,0,8'h00,8'h00));
    tbl[11] = mkv(1,0,4'd1,8'h10, 1,1,4'd2,8'h22, 1,8'h5A, pk(1,1,4'd2,8'h22,0,1,0,0,8'h00,8'h00));
    tbl[12] = mkv(1,0,4'd1,8'h10, 0,0,4'd0,8'h00, 0,8'h00, z);
    tbl[13] = mkv(0,0,4'd1,8'h10, 0,0,4'd0,8'h00, 0,8'h00, pk(1,0,4'd1,8'h10,0,0,0,0,8'h00,8'h00));
    tbl[14] = mkv(0,0,4'd1,8'h10, 0,0,4'd0,8'h00, 1,8'h77, pk(1,0,4'd1,8'h10,1,0,0,0,8'h77,8'h00));
    tbl[15] = mkv(0,0,4'd0,8'h00, 0,0,4'd0,8'h00, 0,8'h00, z);

    // Held in reset with activity on the inputs: everything must read zero
    v0 = 1; a0 = 4'd9; d0 = 8'h55; mr = 1; mrd = 8'hC3;
    repeat (2) @(negedge clk);
    check("reset_state", obs, z);
    v0 = 0; a0 = 0; d0 = 0; mr = 0; mrd = 0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      v0 = tbl[i].iv0; w0 = tbl[i].iw0; a0 = tbl[i].ia0; d0 = tbl[i].id0;
      v1 = tbl[i].iv1; w1 = tbl[i].iw1; a1 = tbl[i].ia1; d1 = tbl[i].id1;
      mr = tbl[i].imr; mrd = tbl[i].imrd;
      @(negedge clk);
      check($sformatf("table_row%0d", i), obs, tbl[i].want);
    end

    // Reset during BUSY drops everything without a clock edge
    @(posedge clk); #1;
    v1 = 1; w1 = 0; a1 = 4'd9; d1 = 8'h00; mr = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_before_reset", obs, pk(1,0,4'd9,8'h00,0,0,0,0,8'h00,8'h00));
    #2;
    rst_n = 1'b0; mr = 1; mrd = 8'hAB;
    #1;
    check("reset_async", obs, z);
    v0 = 1; w0 = 1; a0 = 4'd5; d0 = 8'h44;
    @(negedge clk);
    check("reset_held", obs, z);
    mr = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check("req0_first_after_reset", obs, pk(1,1,4'd5,8'h44,0,0,0,0,8'h00,8'h00));
    @(posedge clk); #1;
    mr = 1;
    @(negedge clk);
    check("req0_done_after_reset", obs, pk(1,1,4'd5,8'h44,1,0,0,0,8'h00,8'h00));
    @(posedge clk); #1;
    v0 = 0; v1 = 0; mr = 0;
    @(posedge clk); #1;

`ifdef ARB_TIMEOUT_EN
    begin
      int bn, err_cyc;
      logic rdy_at;
      bn = 0; err_cyc = -1; rdy_at = 0;
      v0 = 1; w0 = 1; a0 = 4'd2; d0 = 8'h66; mr = 0;
      for (int k = 0; k < 20 && err_cyc < 0; k++) begin
        @(negedge clk);
        if (mv) bn++;
        if (r0 && !e0) begin err_cyc = 0; rdy_at = 0; end
        if (e0) begin err_cyc = bn; rdy_at = r0; end
      end
      check("timeout_cycle", 34'(err_cyc), 34'(T));
      check("timeout_ready", {33'b0, rdy_at}, 34'd1);
      @(posedge clk); #1;
      v0 = 0;
      @(posedge clk); #1;
      v0 = 1;
      repeat (T) @(posedge clk);
      #1;
      mr = 1;
      @(negedge clk);
      check("timeout_vs_ready", {32'b0, r0, e0}, 34'b10);
      @(posedge clk); #1;
      v0 = 0; mr = 0;
    end
`else
    begin
      int lost, errs;
      lost = 0; errs = 0;
      v0 = 1; w0 = 1; a0 = 4'd2; d0 = 8'h66; mr = 0;
      @(negedge clk);
      repeat (100) begin
        @(negedge clk);
        if (!mv || r0) lost++;
        if (e0 || e1) errs++;
      end
      check("hang_stays_busy", 34'(lost), 34'd0);
      check("hang_no_err", 34'(errs), 34'd0);
      @(posedge clk); #1;
      mr = 1;
      @(negedge clk);
      check("hang_release", obs, pk(1,1,4'd2,8'h66,1,0,0,0,8'h00,8'h00));
      @(posedge clk); #1;
      v0 = 0; mr = 0;
    end
`endif

    // Both requesters always valid from reset: grants must alternate starting at req0
    v0 = 1; w0 = 1; a0 = 4'd1; v1 = 1; w1 = 1; a1 = 4'd2; mr = 1;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (r0) order.push_back(0);
      if (r1) order.push_back(1);
    end
    check("rr_count", {33'b0, order.size() >= 8}, 34'd1);
    foreach (order[i]) check($sformatf("rr_grant%0d", i), 34'(order[i]), 34'(i % 2));
    v0 = 0; v1 = 0; mr = 0;

    // Random traffic against the transaction-level model
    do_reset();
    owner = -1; last = 1; busy_n = 0;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 0; pw[i] = 0; pa[i] = 0; pd[i] = 0; strobed[i] = 0;
    end
    for (int n = 0; n < 400; n++) begin
      logic fin_ok, fin_err;
      logic [33:0] want;
      logic [7:0] rdx[2];
      logic rx[2], ex[2];
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (strobed[i] || (!pv[i] && $urandom_range(0, 2) == 0)) begin
          pv[i] = strobed[i] ? 1'($urandom_range(0, 1)) : 1'b1;
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = 4'($urandom);
          pd[i] = 8'($urandom);
        end
      end
      v0 = pv[0]; w0 = pw[0]; a0 = pa[0]; d0 = pd[0];
      v1 = pv[1]; w1 = pw[1]; a1 = pa[1]; d1 = pd[1];
      mr = ($urandom_range(0, 2) != 0);
      mrd = 8'($urandom);
      @(negedge clk);
      fin_ok = 0; fin_err = 0;
      rx[0] = 0; rx[1] = 0; ex[0] = 0; ex[1] = 0; rdx[0] = 0; rdx[1] = 0;
      if (owner >= 0) begin
        fin_ok = mr;
`ifdef ARB_TIMEOUT_EN
        fin_err = !mr && (busy_n == T);
`endif
        rx[owner] = fin_ok || fin_err;
        ex[owner] = fin_err;
        rdx[owner] = (fin_ok && !pw[owner]) ? mrd : 8'h00;
        want = pk(1, pw[owner], pa[owner], pd[owner], rx[0], rx[1], ex[0], ex[1], rdx[0], rdx[1]);
      end else begin
        want = z;
      end
      check($sformatf("random_cycle%0d", n), obs, want);
      strobed[0] = 0; strobed[1] = 0;
      if (owner < 0) begin
        if (pv[0] || pv[1]) begin
          owner = (pv[0] && pv[1]) ? 1 - last : (pv[1] ? 1 : 0);
          busy_n = 1;
        end
      end else if (fin_ok || fin_err) begin
        strobed[owner] = 1;
        last = owner;
        owner = -1;
      end else begin
        busy_n++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
